// File: rtl/shot_ctrl_pkg.sv
// Shared types and constants for the shot_ctrl run sequencer.
//   state_e : sequencer states
//   ERR_*   : sticky error codes reported on err
package shot_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ERR_W  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLRACC = 3'd1,
        START  = 3'd2,
        RUN    = 3'd3,
        ABORT  = 3'd4
    } state_e;

    typedef logic [ERR_W-1:0] err_t;

    localparam err_t ERR_NONE    = 2'd0;
    localparam err_t ERR_NSHOT0  = 2'd1;
    localparam err_t ERR_TIMEOUT = 2'd2;
    localparam err_t ERR_ABORT   = 2'd3;

endpackage

// File: rtl/pulse_stretch.sv
// Fixed-length level pulse generator.
//   clk_i, rst_ni : clock, async active-low reset
//   trig_i        : (re)start a pulse of LEN cycles, beginning next cycle
//   kill_i        : terminate the pulse; takes effect next cycle
//   pulse_o       : registered pulse level
//   last_o        : registered, high during the final pulse cycle
module pulse_stretch #(
    parameter int unsigned LEN = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic trig_i,
    input  logic kill_i,
    output logic pulse_o,
    output logic last_o
);

    localparam int unsigned CW = $clog2(LEN + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Remaining pulse cycles; trigger wins over kill.
    always_comb begin
        cnt_d = cnt_q;
        if (trig_i) begin
            cnt_d = CW'(LEN);
        end else if (kill_i) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            pulse_o <= 1'b0;
            last_o  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_o <= (cnt_d != '0);
            last_o  <= (cnt_d == CW'(1));
        end
    end

endmodule

// File: rtl/shot_ctrl.sv
// Run sequencer in front of the DSP shot engine: turns a host run request
// into resetacc / stb_reset_bram_read / stb_start, waits for lastshotdone,
// enforces a timeout and handles abort via a dsp_reset pulse.
//   clk, reset_n                  : clock, async active-low reset
//   cmd_start, cmd_abort          : one-cycle host commands
//   cfg_nshot, cfg_timeout        : run config, sampled on accepted start
//   stb_start, nshot, resetacc,
//   stb_reset_bram_read, dsp_reset: DSP run control
//   lastshotdone, shotcnt,
//   addr_accbuf_mon               : DSP status
//   busy, done, err, elapsed,
//   acc_fill                      : status to the register file
module shot_ctrl
    import shot_ctrl_pkg::*;
#(
    parameter int unsigned RESETACC_CYC = 4,
    parameter int unsigned BLANK_CYC    = 8,
    parameter int unsigned ABORT_CYC    = 4,
    parameter int unsigned NMON         = 4,
    parameter int unsigned ACC_AW       = 9
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_start,
    input  logic                     cmd_abort,
    input  logic [DATA_W-1:0]        cfg_nshot,
    input  logic [DATA_W-1:0]        cfg_timeout,
    output logic                     stb_start,
    output logic [DATA_W-1:0]        nshot,
    output logic                     resetacc,
    output logic                     stb_reset_bram_read,
    output logic                     dsp_reset,
    input  logic                     lastshotdone,
    input  logic [DATA_W-1:0]        shotcnt,
    input  logic [NMON*ACC_AW-1:0]   addr_accbuf_mon,
    output logic                     busy,
    output logic                     done,
    output logic [ERR_W-1:0]         err,
    output logic [DATA_W-1:0]        elapsed,
    output logic [NMON*ACC_AW-1:0]   acc_fill
);

    localparam int unsigned MON_W = NMON * ACC_AW;
    localparam int unsigned BW    = $clog2(BLANK_CYC + 1);

    state_e             state_q;
    logic               stb_start_q;
    logic               stb_brr_q;
    logic [DATA_W-1:0]  nshot_q;
    logic [DATA_W-1:0]  timeout_q;
    logic               busy_q;
    logic               done_q;
    err_t               err_q;
    logic [DATA_W-1:0]  elapsed_q;
    logic [MON_W-1:0]   acc_fill_q;
    logic [BW-1:0]      blank_q;
    logic [DATA_W-1:0]  shotcnt_dbg_q;

    logic               active_c;
    logic               start_ok_c;
    logic               blank_over_c;
    logic               shot_done_c;
    logic               timeout_c;
    logic               abort_go_c;
    logic               ra_kill_c;
    logic [DATA_W-1:0]  elapsed_inc_c;
    logic               ra_pulse;
    logic               ra_last;
    logic               ab_pulse;
    logic               ab_last;
    logic               unused_shotcnt_c;

    // Event decode for the sequencer.
    assign active_c      = (state_q == CLRACC) || (state_q == START) || (state_q == RUN);
    assign start_ok_c    = (state_q == IDLE) && cmd_start && (cfg_nshot != '0);
    assign blank_over_c  = (blank_q >= BW'(BLANK_CYC));
    assign shot_done_c   = (state_q == RUN) && blank_over_c && lastshotdone;
    assign timeout_c     = (state_q == RUN) && (timeout_q != '0)
                           && (elapsed_q == timeout_q - DATA_W'(1));
    // Abort beats completion; completion beats timeout.
    assign abort_go_c    = (active_c && cmd_abort) || (timeout_c && !shot_done_c);
    assign ra_kill_c     = (state_q == CLRACC) && cmd_abort;
    assign elapsed_inc_c = (elapsed_q == '1) ? elapsed_q : elapsed_q + DATA_W'(1);

    // shotcnt is captured for debug visibility only.
    assign unused_shotcnt_c = ^shotcnt_dbg_q;

    pulse_stretch #(.LEN(RESETACC_CYC)) u_resetacc (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .trig_i  (start_ok_c),
        .kill_i  (ra_kill_c),
        .pulse_o (ra_pulse),
        .last_o  (ra_last)
    );

    pulse_stretch #(.LEN(ABORT_CYC)) u_dsp_reset (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .trig_i  (abort_go_c),
        .kill_i  (1'b0),
        .pulse_o (ab_pulse),
        .last_o  (ab_last)
    );

    // Sequencer FSM with registered status and strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            stb_start_q   <= 1'b0;
            stb_brr_q     <= 1'b0;
            nshot_q       <= '0;
            timeout_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= ERR_NONE;
            elapsed_q     <= '0;
            acc_fill_q    <= '0;
            blank_q       <= '0;
            shotcnt_dbg_q <= '0;
        end else begin
            stb_start_q   <= 1'b0;
            stb_brr_q     <= 1'b0;
            shotcnt_dbg_q <= shotcnt;
            unique case (state_q)
                IDLE: begin
                    if (start_ok_c) begin
                        nshot_q    <= cfg_nshot;
                        timeout_q  <= cfg_timeout;
                        done_q     <= 1'b0;
                        err_q      <= ERR_NONE;
                        elapsed_q  <= '0;
                        acc_fill_q <= '0;
                        busy_q     <= 1'b1;
                        stb_brr_q  <= 1'b1;
                        state_q    <= CLRACC;
                    end else if (cmd_start) begin
                        err_q <= ERR_NSHOT0;
                    end
                end
                CLRACC: begin
                    if (cmd_abort) begin
                        err_q      <= ERR_ABORT;
                        acc_fill_q <= addr_accbuf_mon;
                        state_q    <= ABORT;
                    end else if (ra_last) begin
                        stb_start_q <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    if (cmd_abort) begin
                        err_q      <= ERR_ABORT;
                        acc_fill_q <= addr_accbuf_mon;
                        state_q    <= ABORT;
                    end else begin
                        elapsed_q <= '0;
                        blank_q   <= '0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (cmd_abort) begin
                        err_q      <= ERR_ABORT;
                        acc_fill_q <= addr_accbuf_mon;
                        state_q    <= ABORT;
                    end else if (shot_done_c) begin
                        elapsed_q  <= elapsed_inc_c;
                        acc_fill_q <= addr_accbuf_mon;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else if (timeout_c) begin
                        err_q      <= ERR_TIMEOUT;
                        acc_fill_q <= addr_accbuf_mon;
                        state_q    <= ABORT;
                    end else begin
                        elapsed_q <= elapsed_inc_c;
                        if (!blank_over_c) begin
                            blank_q <= blank_q + BW'(1);
                        end
                    end
                end
                ABORT: begin
                    if (ab_last) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stb_start           = stb_start_q;
    assign stb_reset_bram_read = stb_brr_q;
    assign resetacc            = ra_pulse;
    assign dsp_reset           = ab_pulse;
    assign nshot               = nshot_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign err                 = err_q;
    assign elapsed             = elapsed_q;
    assign acc_fill            = acc_fill_q;

endmodule

// File: tb/tb_shot_ctrl.sv
// Directed scoreboard bench for shot_ctrl.
module tb_shot_ctrl;
    import shot_ctrl_pkg::*;

    localparam int unsigned NMON   = 4;
    localparam int unsigned ACC_AW = 9;
    localparam int unsigned MW     = NMON * ACC_AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_abort = 1'b0;
    logic [31:0]   cfg_nshot = '0;
    logic [31:0]   cfg_timeout = '0;
    logic          lastshotdone = 1'b0;
    logic [31:0]   shotcnt = '0;
    logic [MW-1:0] addr_accbuf_mon = '0;

    logic          stb_start;
    logic [31:0]   nshot;
    logic          resetacc;
    logic          stb_reset_bram_read;
    logic          dsp_reset;
    logic          busy;
    logic          done;
    logic [1:0]    err;
    logic [31:0]   elapsed;
    logic [MW-1:0] acc_fill;

    shot_ctrl #(
        .RESETACC_CYC (4),
        .BLANK_CYC    (8),
        .ABORT_CYC    (4),
        .NMON         (NMON),
        .ACC_AW       (ACC_AW)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .cmd_start           (cmd_start),
        .cmd_abort           (cmd_abort),
        .cfg_nshot           (cfg_nshot),
        .cfg_timeout         (cfg_timeout),
        .stb_start           (stb_start),
        .nshot               (nshot),
        .resetacc            (resetacc),
        .stb_reset_bram_read (stb_reset_bram_read),
        .dsp_reset           (dsp_reset),
        .lastshotdone        (lastshotdone),
        .shotcnt             (shotcnt),
        .addr_accbuf_mon     (addr_accbuf_mon),
        .busy                (busy),
        .done                (done),
        .err                 (err),
        .elapsed             (elapsed),
        .acc_fill            (acc_fill)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe/pulse monitor, sampled mid-cycle.
    int   stb_cnt = 0;
    int   ra_cnt = 0;
    int   ra_rise = -1;
    int   ra_fall = -1;
    int   brr_cnt = 0;
    int   brr_cyc = -1;
    int   dr_cnt = 0;
    logic ra_prev = 1'b0;
    always @(negedge clk) begin
        if (stb_start) stb_cnt <= stb_cnt + 1;
        if (resetacc) begin
            ra_cnt  <= ra_cnt + 1;
            ra_fall <= cyc;
            if (!ra_prev) ra_rise <= cyc;
        end
        ra_prev <= resetacc;
        if (stb_reset_bram_read) begin
            brr_cnt <= brr_cnt + 1;
            brr_cyc <= cyc;
        end
        if (dsp_reset) dr_cnt <= dr_cnt + 1;
    end

    // Scoreboard of expected observations, consumed in order.
    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            e.tag = "scoreboard_empty";
            e.exp = 64'hdead_beef_dead_beef;
        end else begin
            e = sb.pop_front();
        end
        assert (obs === e.exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Bounded wait for stb_start; returns its cycle or -1.
    task automatic wait_stb(output int s);
        s = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stb_start === 1'b1) begin
                s = cyc;
                break;
            end
        end
    endtask

    function automatic logic [MW-1:0] mk_mon(input int base, input int stp);
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < int'(NMON); i++) begin
            m[i*ACC_AW +: ACC_AW] = ACC_AW'(base + i * stp);
        end
        return m;
    endfunction

    int t0, s;
    int ra0, brr0, stb0, dr0;

    initial begin
        // Reset state
        push("rst_ctrl", 64'd0);
        push("rst_nshot", 64'd0);
        push("rst_elapsed_fill", 64'd0);
        repeat (3) step();
        smp();
        chk(64'({busy, done, err, stb_start, resetacc, stb_reset_bram_read, dsp_reset}));
        chk(64'(nshot));
        chk(64'(elapsed) | 64'(acc_fill));
        step();
        reset_n = 1'b1;

        // Normal run: ordering, latency, completion 20 cycles after stb_start
        step();
        cfg_nshot = 32'd3; cfg_timeout = 32'd0;
        addr_accbuf_mon = mk_mon(5, 0);
        cmd_start = 1'b1;
        t0 = cyc; ra0 = ra_cnt; brr0 = brr_cnt; stb0 = stb_cnt;
        push("t1_stb_cyc", 64'(t0 + 5));
        push("t1_nshot", 64'd3);
        push("t1_busy", 64'd1);
        push("t1_busy_pre", 64'd1);
        push("t1_done", 64'd1);
        push("t1_busy_post", 64'd0);
        push("t1_elapsed", 64'd20);
        push("t1_acc_fill", 64'(mk_mon(5, 0)));
        push("t1_err", 64'(ERR_NONE));
        push("t1_ra_cnt", 64'd4);
        push("t1_ra_rise", 64'(t0 + 1));
        push("t1_ra_fall", 64'(t0 + 4));
        push("t1_brr_cnt", 64'd1);
        push("t1_brr_cyc", 64'(t0 + 1));
        push("t1_stb_cnt", 64'd1);
        step();
        cmd_start = 1'b0;
        wait_stb(s);
        chk(64'(s));
        chk(64'(nshot));
        chk(64'(busy));
        repeat (20) step();
        lastshotdone = 1'b1;
        smp();
        chk(64'(busy));
        step();
        smp();
        chk(64'(done));
        chk(64'(busy));
        chk(64'(elapsed));
        chk(64'(acc_fill));
        chk(64'(err));
        chk(64'(ra_cnt - ra0));
        chk(64'(ra_rise));
        chk(64'(ra_fall));
        chk(64'(brr_cnt - brr0));
        chk(64'(brr_cyc));
        chk(64'(stb_cnt - stb0));

        // Stale lastshotdone held through blanking must not complete the run
        step();
        cfg_nshot = 32'd7;
        addr_accbuf_mon = mk_mon(10, 1);
        cmd_start = 1'b1;
        t0 = cyc;
        push("t3_done_clr", 64'd0);
        push("t3_stb_cyc", 64'(t0 + 5));
        push("t3_busy_blank", 64'd1);
        push("t3_done_blank", 64'd0);
        push("t3_done", 64'd1);
        push("t3_elapsed", 64'd30);
        push("t3_acc_fill", 64'(mk_mon(10, 1)));
        push("t3_nshot", 64'd7);
        step();
        cmd_start = 1'b0;
        smp();
        chk(64'(done));
        wait_stb(s);
        chk(64'(s));
        repeat (8) step();
        lastshotdone = 1'b0;
        smp();
        chk(64'(busy));
        chk(64'(done));
        repeat (22) step();
        lastshotdone = 1'b1;
        step();
        lastshotdone = 1'b0;
        smp();
        chk(64'(done));
        chk(64'(elapsed));
        chk(64'(acc_fill));
        chk(64'(nshot));

        // Timeout = 100 with no lastshotdone
        step();
        cfg_nshot = 32'd2; cfg_timeout = 32'd100;
        addr_accbuf_mon = mk_mon(20, 2);
        cmd_start = 1'b1;
        push("t4_err_pre", 64'(ERR_NONE));
        push("t4_dsp_reset_pre", 64'd0);
        push("t4_err", 64'(ERR_TIMEOUT));
        push("t4_dsp_reset", 64'd1);
        push("t4_elapsed", 64'd99);
        push("t4_acc_fill", 64'(mk_mon(20, 2)));
        push("t4_busy_abort", 64'd1);
        push("t4_busy_end", 64'd0);
        push("t4_dsp_reset_end", 64'd0);
        push("t4_done", 64'd0);
        push("t4_dr_cnt", 64'd4);
        push("t4_err_hold", 64'(ERR_TIMEOUT));
        step();
        cmd_start = 1'b0;
        wait_stb(s);
        dr0 = dr_cnt;
        repeat (100) step();
        smp();
        chk(64'(err));
        chk(64'(dsp_reset));
        step();
        smp();
        chk(64'(err));
        chk(64'(dsp_reset));
        chk(64'(elapsed));
        chk(64'(acc_fill));
        repeat (3) step();
        smp();
        chk(64'(busy));
        step();
        smp();
        chk(64'(busy));
        chk(64'(dsp_reset));
        chk(64'(done));
        chk(64'(dr_cnt - dr0));
        chk(64'(err));

        // cfg_nshot == 0 is rejected with no DSP activity
        step();
        cfg_nshot = 32'd0; cfg_timeout = 32'd0;
        cmd_start = 1'b1;
        stb0 = stb_cnt; ra0 = ra_cnt; brr0 = brr_cnt;
        push("t5_err_nshot0", 64'(ERR_NSHOT0));
        push("t5_busy_nshot0", 64'd0);
        push("t5_no_strobes", 64'd0);
        step();
        cmd_start = 1'b0;
        smp();
        chk(64'(err));
        chk(64'(busy));
        repeat (6) step();
        smp();
        chk(64'((stb_cnt - stb0) + (ra_cnt - ra0) + (brr_cnt - brr0)));

        // Start+abort together in IDLE: start wins; then abort during CLRACC
        step();
        cfg_nshot = 32'd5;
        cmd_start = 1'b1; cmd_abort = 1'b1;
        stb0 = stb_cnt;
        push("t6_busy", 64'd1);
        push("t6_err", 64'(ERR_NONE));
        push("t6_resetacc", 64'd1);
        push("t6_resetacc_drop", 64'd0);
        push("t6_err_abort", 64'(ERR_ABORT));
        push("t6_dsp_reset", 64'd1);
        push("t6_busy_end", 64'd0);
        push("t6_no_stb", 64'd0);
        step();
        cmd_start = 1'b0; cmd_abort = 1'b0;
        smp();
        chk(64'(busy));
        chk(64'(err));
        chk(64'(resetacc));
        step();
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        smp();
        chk(64'(resetacc));
        chk(64'(err));
        chk(64'(dsp_reset));
        repeat (4) step();
        smp();
        chk(64'(busy));
        chk(64'(stb_cnt - stb0));

        // Abort in RUN; cmd_start while busy is ignored
        step();
        cfg_nshot = 32'd5;
        cmd_start = 1'b1;
        dr0 = dr_cnt;
        push("t7_nshot_busy", 64'd5);
        push("t7_busy", 64'd1);
        push("t7_err", 64'(ERR_ABORT));
        push("t7_dsp_reset", 64'd1);
        push("t7_acc_fill", 64'(mk_mon(30, 3)));
        push("t7_busy_end", 64'd0);
        push("t7_done", 64'd0);
        push("t7_dr_cnt", 64'd4);
        push("t7_nshot_end", 64'd5);
        step();
        cmd_start = 1'b0;
        wait_stb(s);
        repeat (5) step();
        cfg_nshot = 32'd9;
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        smp();
        chk(64'(nshot));
        chk(64'(busy));
        repeat (4) step();
        cmd_abort = 1'b1;
        addr_accbuf_mon = mk_mon(30, 3);
        step();
        cmd_abort = 1'b0;
        smp();
        chk(64'(err));
        chk(64'(dsp_reset));
        chk(64'(acc_fill));
        repeat (4) step();
        smp();
        chk(64'(busy));
        chk(64'(done));
        chk(64'(dr_cnt - dr0));
        chk(64'(nshot));

        // Asynchronous reset mid-RUN, then a fresh normal run
        step();
        cfg_nshot = 32'd6;
        cmd_start = 1'b1;
        push("t8_rst_ctrl", 64'd0);
        push("t8_rst_nshot", 64'd0);
        push("t8_rst_elapsed_fill", 64'd0);
        step();
        cmd_start = 1'b0;
        wait_stb(s);
        repeat (5) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk(64'({busy, done, err, stb_start, resetacc, stb_reset_bram_read, dsp_reset}));
        chk(64'(nshot));
        chk(64'(elapsed) | 64'(acc_fill));
        step();
        reset_n = 1'b1;
        step();
        cfg_nshot = 32'd4;
        addr_accbuf_mon = mk_mon(40, 1);
        cmd_start = 1'b1;
        t0 = cyc;
        push("t8_stb_cyc", 64'(t0 + 5));
        push("t8_done", 64'd1);
        push("t8_elapsed", 64'd12);
        push("t8_nshot", 64'd4);
        push("t8_acc_fill", 64'(mk_mon(40, 1)));
        step();
        cmd_start = 1'b0;
        wait_stb(s);
        chk(64'(s));
        repeat (12) step();
        lastshotdone = 1'b1;
        step();
        lastshotdone = 1'b0;
        smp();
        chk(64'(done));
        chk(64'(elapsed));
        chk(64'(nshot));
        chk(64'(acc_fill));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
